// File: rtl/ps2_pkg.sv
// Shared types and default screen geometry for the PS/2 cursor tracker.
// Field widths of a decoded mouse packet live here so every file agrees on them.
package ps2_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_CALC   = 2'd1,
      ST_COMMIT = 2'd2
   } ps2_state_e;

   localparam int DEF_XMAX  = 639;
   localparam int DEF_YMAX  = 479;
   localparam int DEF_XINIT = 320;
   localparam int DEF_YINIT = 240;

   localparam int BTN_W = 3;
   localparam int DX_W  = 9;
   localparam int DZ_W  = 4;

endpackage

// File: rtl/ps2_cursor_tracker_if.sv
// Decoded PS/2 packet bus: a one-cycle valid strobe with buttons and signed deltas.
interface ps2_cursor_tracker_if;
   import ps2_pkg::*;

   logic             pkt_valid;
   logic [BTN_W-1:0] btn;
   logic [DX_W-1:0]  dx;
   logic [DX_W-1:0]  dy;
   logic [DZ_W-1:0]  dz;

   modport master (output pkt_valid, btn, dx, dy, dz);
   modport slave  (input  pkt_valid, btn, dx, dy, dz);

endinterface

// File: rtl/ps2_axis_accum.sv
// One cursor axis: scale a signed delta, add it to the current position and
// clamp or wrap the result into 0..MAX. Purely combinational.
module ps2_axis_accum
   import ps2_pkg::*;
#(
   parameter int CW    = 11,
   parameter int MAX   = DEF_XMAX,
   parameter int SHIFT = 0,
   parameter int WRAP  = 0,
   parameter int INV   = 0
) (
   input  logic [CW-1:0]   cur,
   input  logic [DX_W-1:0] delta,
   output logic [CW-1:0]   nxt
);
   localparam int SW = CW + SHIFT + 2;
   localparam logic signed [SW-1:0] MAX_S = SW'(MAX);
   localparam logic signed [SW-1:0] MOD_S = SW'(MAX + 1);

   logic signed [SW-1:0] scaled;
   logic signed [SW-1:0] limited;
   logic signed [SW-1:0] sum;
   logic signed [SW-1:0] adj;

   always_comb begin
      scaled  = {{(SW-DX_W){delta[DX_W-1]}}, delta} <<< SHIFT;
      limited = scaled;
      if (WRAP != 0) begin
         // one +/-(MAX+1) correction only suffices if the step is within one screen
         if (scaled > MAX_S) begin
            limited = MAX_S;
         end else if (scaled < -MAX_S) begin
            limited = -MAX_S;
         end
      end
      sum = $signed({{(SW-CW){1'b0}}, cur}) + ((INV != 0) ? -limited : limited);
      adj = sum;
      if (sum[SW-1]) begin
         adj = (WRAP != 0) ? sum + MOD_S : '0;
      end else if (sum > MAX_S) begin
         adj = (WRAP != 0) ? sum - MOD_S : MAX_S;
      end
      nxt = adj[CW-1:0];
   end

endmodule

// File: rtl/ps2_cursor_tracker.sv
// Tracks cursor position, wheel and buttons from decoded PS/2 packets through a
// three-state IDLE/CALC/COMMIT pipeline; packets arriving while busy are counted and dropped.
module ps2_cursor_tracker
   import ps2_pkg::*;
#(
   parameter int CW    = 11,
   parameter int XMAX  = DEF_XMAX,
   parameter int YMAX  = DEF_YMAX,
   parameter int XINIT = DEF_XINIT,
   parameter int YINIT = DEF_YINIT,
   parameter int SHIFT = 0,
   parameter int WRAP  = 0,
   parameter int ZW    = 8
) (
   input  logic                   clk,
   input  logic                   rst_n,
   ps2_cursor_tracker_if.slave    pkt_if,
   input  logic                   recenter,
   output logic [CW-1:0]          xs,
   output logic [CW-1:0]          ys,
   output logic signed [ZW-1:0]   zacc,
   output logic [BTN_W-1:0]       lrm,
   output logic [BTN_W-1:0]       press,
   output logic [BTN_W-1:0]       release_pulse,
   output logic                   upd,
   output logic                   busy,
   output logic [7:0]             drop_cnt
);
   localparam logic signed [ZW-1:0] Z_MAX = {1'b0, {(ZW-1){1'b1}}};
   localparam logic signed [ZW-1:0] Z_MIN = {1'b1, {(ZW-1){1'b0}}};

   ps2_state_e state_q, state_d;

   logic [BTN_W-1:0]     btn_hold_q, btn_hold_d;
   logic [DX_W-1:0]      dx_hold_q, dx_hold_d;
   logic [DX_W-1:0]      dy_hold_q, dy_hold_d;
   logic [DZ_W-1:0]      dz_hold_q, dz_hold_d;
   logic [CW-1:0]        x_calc_q, x_calc_d;
   logic [CW-1:0]        y_calc_q, y_calc_d;
   logic signed [ZW-1:0] z_calc_q, z_calc_d;
   logic [CW-1:0]        xs_q, xs_d;
   logic [CW-1:0]        ys_q, ys_d;
   logic signed [ZW-1:0] zacc_q, zacc_d;
   logic [BTN_W-1:0]     lrm_q, lrm_d;
   logic [BTN_W-1:0]     press_q, press_d;
   logic [BTN_W-1:0]     rel_q, rel_d;
   logic                 upd_q, upd_d;
   logic                 busy_q, busy_d;
   logic [7:0]           drop_q, drop_d;

   logic [CW-1:0]        x_nxt;
   logic [CW-1:0]        y_nxt;
   logic signed [ZW:0]   z_sum;
   logic signed [ZW-1:0] z_nxt;

   ps2_axis_accum #(.CW(CW), .MAX(XMAX), .SHIFT(SHIFT), .WRAP(WRAP), .INV(0)) u_axis_x (
      .cur   (xs_q),
      .delta (dx_hold_q),
      .nxt   (x_nxt)
   );

   // Y delta is mouse-up positive while the screen counts downward
   ps2_axis_accum #(.CW(CW), .MAX(YMAX), .SHIFT(SHIFT), .WRAP(WRAP), .INV(1)) u_axis_y (
      .cur   (ys_q),
      .delta (dy_hold_q),
      .nxt   (y_nxt)
   );

   always_comb begin
      z_sum = {zacc_q[ZW-1], zacc_q} + {{(ZW+1-DZ_W){dz_hold_q[DZ_W-1]}}, dz_hold_q};
      if (z_sum[ZW] != z_sum[ZW-1]) begin
         z_nxt = z_sum[ZW] ? Z_MIN : Z_MAX;
      end else begin
         z_nxt = z_sum[ZW-1:0];
      end
   end

   always_comb begin
      state_d    = state_q;
      btn_hold_d = btn_hold_q;
      dx_hold_d  = dx_hold_q;
      dy_hold_d  = dy_hold_q;
      dz_hold_d  = dz_hold_q;
      x_calc_d   = x_calc_q;
      y_calc_d   = y_calc_q;
      z_calc_d   = z_calc_q;
      xs_d       = xs_q;
      ys_d       = ys_q;
      zacc_d     = zacc_q;
      lrm_d      = lrm_q;
      press_d    = '0;
      rel_d      = '0;
      upd_d      = 1'b0;
      drop_d     = drop_q;

      if (recenter) begin
         // a packet arriving alongside recenter is simply discarded, not counted
         state_d = ST_IDLE;
         xs_d    = CW'(XINIT);
         ys_d    = CW'(YINIT);
         zacc_d  = '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (pkt_if.pkt_valid) begin
                  btn_hold_d = pkt_if.btn;
                  dx_hold_d  = pkt_if.dx;
                  dy_hold_d  = pkt_if.dy;
                  dz_hold_d  = pkt_if.dz;
                  state_d    = ST_CALC;
               end
            end
            ST_CALC: begin
               x_calc_d = x_nxt;
               y_calc_d = y_nxt;
               z_calc_d = z_nxt;
               state_d  = ST_COMMIT;
               if (pkt_if.pkt_valid && drop_q != 8'hFF) begin
                  drop_d = drop_q + 8'd1;
               end
            end
            ST_COMMIT: begin
               xs_d    = x_calc_q;
               ys_d    = y_calc_q;
               zacc_d  = z_calc_q;
               press_d = btn_hold_q & ~lrm_q;
               rel_d   = ~btn_hold_q & lrm_q;
               lrm_d   = btn_hold_q;
               upd_d   = 1'b1;
               state_d = ST_IDLE;
               if (pkt_if.pkt_valid && drop_q != 8'hFF) begin
                  drop_d = drop_q + 8'd1;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         btn_hold_q <= '0;
         dx_hold_q  <= '0;
         dy_hold_q  <= '0;
         dz_hold_q  <= '0;
         x_calc_q   <= '0;
         y_calc_q   <= '0;
         z_calc_q   <= '0;
         xs_q       <= CW'(XINIT);
         ys_q       <= CW'(YINIT);
         zacc_q     <= '0;
         lrm_q      <= '0;
         press_q    <= '0;
         rel_q      <= '0;
         upd_q      <= 1'b0;
         busy_q     <= 1'b0;
         drop_q     <= '0;
      end else begin
         state_q    <= state_d;
         btn_hold_q <= btn_hold_d;
         dx_hold_q  <= dx_hold_d;
         dy_hold_q  <= dy_hold_d;
         dz_hold_q  <= dz_hold_d;
         x_calc_q   <= x_calc_d;
         y_calc_q   <= y_calc_d;
         z_calc_q   <= z_calc_d;
         xs_q       <= xs_d;
         ys_q       <= ys_d;
         zacc_q     <= zacc_d;
         lrm_q      <= lrm_d;
         press_q    <= press_d;
         rel_q      <= rel_d;
         upd_q      <= upd_d;
         busy_q     <= busy_d;
         drop_q     <= drop_d;
      end
   end

   assign xs            = xs_q;
   assign ys            = ys_q;
   assign zacc          = zacc_q;
   assign lrm           = lrm_q;
   assign press         = press_q;
   assign release_pulse = rel_q;
   assign upd           = upd_q;
   assign busy          = busy_q;
   assign drop_cnt      = drop_q;

endmodule

// File: tb/tb_ps2_cursor_tracker.sv
// Drives three tracker variants (default, SHIFT=2, WRAP=1) from one packet bus and
// checks every cycle against a packet-level model of cursor, wheel and button behaviour.
module tb_ps2_cursor_tracker;
   localparam int NCFG = 3;
   localparam int XMAX = 639;
   localparam int YMAX = 479;
   localparam int XINIT = 320;
   localparam int YINIT = 240;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   logic recenter = 1'b0;

   ps2_cursor_tracker_if pif();

   logic [10:0]       xs_w   [NCFG];
   logic [10:0]       ys_w   [NCFG];
   logic signed [7:0] zacc_w [NCFG];
   logic [2:0]        lrm_w  [NCFG];
   logic [2:0]        press_w[NCFG];
   logic [2:0]        rel_w  [NCFG];
   logic              upd_w  [NCFG];
   logic              busy_w [NCFG];
   logic [7:0]        drop_w [NCFG];

   always #5 clk = ~clk;

   for (genvar gi = 0; gi < NCFG; gi++) begin : g_dut
      ps2_cursor_tracker #(
         .CW(11), .XMAX(XMAX), .YMAX(YMAX), .XINIT(XINIT), .YINIT(YINIT),
         .SHIFT((gi == 1) ? 2 : 0), .WRAP((gi == 2) ? 1 : 0), .ZW(8)
      ) u_dut (
         .clk           (clk),
         .rst_n         (rst_n),
         .pkt_if        (pif),
         .recenter      (recenter),
         .xs            (xs_w[gi]),
         .ys            (ys_w[gi]),
         .zacc          (zacc_w[gi]),
         .lrm           (lrm_w[gi]),
         .press         (press_w[gi]),
         .release_pulse (rel_w[gi]),
         .upd           (upd_w[gi]),
         .busy          (busy_w[gi]),
         .drop_cnt      (drop_w[gi])
      );
   end

   int total = 0;
   int bad = 0;
   int nprint = 0;

   task automatic chk(input string nm, input int c, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         if (nprint < 40) begin
            nprint++;
            $display("FAIL %s cfg%0d t=%0t: got %0d want %0d", nm, c, $time, act, exp);
         end
      end
   endtask

   // ---------------- behavioural model ----------------
   int mx[NCFG];
   int my[NCFG];
   int mz, mlrm, mpress, mrel, mupd, mdrop;
   int mage;                 // -1 none, 0 packet just taken, 1 packet one cycle old
   int hb, hdx, hdy, hdz;

   function automatic int cfg_shift(input int c);
      return (c == 1) ? 2 : 0;
   endfunction

   function automatic int cfg_wrap(input int c);
      return (c == 2) ? 1 : 0;
   endfunction

   function automatic int axis(input int cur, input int d, input int sh, input int wr,
                               input int lim, input int inv);
      int s;
      int sum;
      s = d * (1 << sh);
      if (wr != 0 && s > lim)  s = lim;
      if (wr != 0 && s < -lim) s = -lim;
      sum = (inv != 0) ? cur - s : cur + s;
      if (sum < 0)   return (wr != 0) ? sum + lim + 1 : 0;
      if (sum > lim) return (wr != 0) ? sum - lim - 1 : lim;
      return sum;
   endfunction

   function automatic void model_drop();
      if (mdrop < 255) mdrop++;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int c = 0; c < NCFG; c++) begin
            mx[c] = XINIT;
            my[c] = YINIT;
         end
         mz = 0; mlrm = 0; mpress = 0; mrel = 0; mupd = 0; mdrop = 0; mage = -1;
         hb = 0; hdx = 0; hdy = 0; hdz = 0;
      end else begin
         mpress = 0; mrel = 0; mupd = 0;
         if (recenter) begin
            for (int c = 0; c < NCFG; c++) begin
               mx[c] = XINIT;
               my[c] = YINIT;
            end
            mz = 0;
            mage = -1;
         end else if (mage == 1) begin
            for (int c = 0; c < NCFG; c++) begin
               mx[c] = axis(mx[c], hdx, cfg_shift(c), cfg_wrap(c), XMAX, 0);
               my[c] = axis(my[c], hdy, cfg_shift(c), cfg_wrap(c), YMAX, 1);
            end
            mz = mz + hdz;
            if (mz > 127)  mz = 127;
            if (mz < -128) mz = -128;
            mpress = hb & ~mlrm & 7;
            mrel   = ~hb & mlrm & 7;
            mlrm   = hb;
            mupd   = 1;
            mage   = -1;
            if (pif.pkt_valid) model_drop();
         end else if (mage == 0) begin
            mage = 1;
            if (pif.pkt_valid) model_drop();
         end else if (pif.pkt_valid) begin
            hb  = int'(pif.btn);
            hdx = int'($signed(pif.dx));
            hdy = int'($signed(pif.dy));
            hdz = int'($signed(pif.dz));
            mage = 0;
         end
      end
   end

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin
      for (int c = 0; c < NCFG; c++) begin
         chk("xs", c, int'(xs_w[c]), mx[c]);
         chk("ys", c, int'(ys_w[c]), my[c]);
         chk("zacc", c, int'(zacc_w[c]), mz);
         chk("lrm", c, int'(lrm_w[c]), mlrm);
         chk("press", c, int'(press_w[c]), mpress);
         chk("release", c, int'(rel_w[c]), mrel);
         chk("upd", c, int'(upd_w[c]), mupd);
         chk("busy", c, int'(busy_w[c]), (mage >= 0) ? 1 : 0);
         chk("drop_cnt", c, int'(drop_w[c]), mdrop);
      end
   end

   // ---------------- stimulus ----------------
   task automatic idle_bus();
      pif.pkt_valid = 1'b0;
   endtask

   // One packet; returns on the cycle its commit is visible.
   task automatic pkt(input logic [2:0] b, input int x, input int y, input int z);
      @(negedge clk);
      pif.pkt_valid = 1'b1;
      pif.btn = b;
      pif.dx = 9'(x);
      pif.dy = 9'(y);
      pif.dz = 4'(z);
      @(negedge clk);
      pif.pkt_valid = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic do_recenter();
      @(negedge clk);
      recenter = 1'b1;
      @(negedge clk);
      recenter = 1'b0;
   endtask

   initial begin
      pif.pkt_valid = 1'b0;
      pif.btn = '0;
      pif.dx = '0;
      pif.dy = '0;
      pif.dz = '0;
      #2 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst_xs", 0, int'(xs_w[0]), 320);
      chk("rst_ys", 0, int'(ys_w[0]), 240);
      chk("rst_zacc", 0, int'(zacc_w[0]), 0);
      chk("rst_drop", 0, int'(drop_w[0]), 0);

      // back-to-back strobes: the second lands in CALC and is dropped
      pif.pkt_valid = 1'b1;
      pif.btn = 3'b000; pif.dx = '0; pif.dy = '0; pif.dz = '0;
      @(negedge clk);
      @(negedge clk);
      idle_bus();
      repeat (3) @(negedge clk);
      chk("drop_one", 0, int'(drop_w[0]), 1);
      chk("model_drop_one", 0, mdrop, 1);

      pkt(3'b001, 100, 0, 0);
      chk("upd_pulse", 0, int'(upd_w[0]), 1);
      chk("xs_plus100", 0, int'(xs_w[0]), 420);
      chk("model_xs_plus100", 0, mx[0], 420);
      chk("press_l", 0, int'(press_w[0]), 1);
      @(negedge clk);
      pkt(3'b010, 255, 0, 0);
      chk("xs_clamp", 0, int'(xs_w[0]), 639);
      chk("model_xs_clamp", 0, mx[0], 639);
      chk("press_r", 0, int'(press_w[0]), 2);
      chk("release_l", 0, int'(rel_w[0]), 1);

      // wrap variant walks to 630, then across both edges
      do_recenter();
      chk("recenter_xs", 0, int'(xs_w[0]), 320);
      pkt(3'b000, 255, 0, 0);
      pkt(3'b000, 55, 0, 0);
      chk("wrap_630", 2, int'(xs_w[2]), 630);
      pkt(3'b000, 20, 0, 0);
      chk("wrap_right", 2, int'(xs_w[2]), 10);
      chk("model_wrap_right", 2, mx[2], 10);
      chk("clamp_right", 0, int'(xs_w[0]), 639);
      pkt(3'b000, -5, 0, 0);
      pkt(3'b000, -10, 0, 0);
      chk("wrap_left", 2, int'(xs_w[2]), 635);
      chk("model_wrap_left", 2, mx[2], 635);

      // gain of 4 on Y
      do_recenter();
      pkt(3'b000, 0, 10, 0);
      chk("shift_dy10", 1, int'(ys_w[1]), 200);
      chk("model_shift_dy10", 1, my[1], 200);
      pkt(3'b000, 0, -256, 0);
      chk("shift_clamp", 1, int'(ys_w[1]), 479);

      // recenter while the packet sits in CALC
      pkt(3'b000, 10, 0, 3);
      chk("pre_abort_xs", 0, int'(xs_w[0]), 330);
      @(negedge clk);
      pif.pkt_valid = 1'b1;
      pif.dx = 9'd50; pif.dz = 4'd2;
      @(negedge clk);
      pif.pkt_valid = 1'b0;
      recenter = 1'b1;
      @(negedge clk);
      recenter = 1'b0;
      @(negedge clk);
      chk("abort_no_upd", 0, int'(upd_w[0]), 0);
      chk("abort_xs", 0, int'(xs_w[0]), 320);
      chk("abort_zacc", 0, int'(zacc_w[0]), 0);

      for (int i = 0; i < 200; i++) pkt(3'b000, 0, 0, 1);
      chk("zacc_sat", 0, int'(zacc_w[0]), 127);
      chk("model_zacc_sat", 0, mz, 127);

      // continuous strobe: two of every three are dropped
      for (int i = 0; i < 450; i++) begin
         @(negedge clk);
         pif.pkt_valid = 1'b1;
         pif.btn = 3'($urandom);
         pif.dx = 9'($urandom);
         pif.dy = 9'($urandom);
         pif.dz = 4'($urandom);
      end
      @(negedge clk);
      idle_bus();
      chk("drop_sat", 0, int'(drop_w[0]), 255);
      chk("model_drop_sat", 0, mdrop, 255);

      // random traffic with occasional recenter and reset
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         rst_n = ($urandom_range(0, 399) != 0);
         recenter = ($urandom_range(0, 99) < 3);
         pif.pkt_valid = ($urandom_range(0, 99) < 40);
         pif.btn = 3'($urandom);
         pif.dx = 9'($urandom);
         pif.dy = 9'($urandom);
         pif.dz = 4'($urandom);
      end
      @(negedge clk);
      rst_n = 1'b1;
      recenter = 1'b0;
      idle_bus();
      repeat (4) @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
